// File: rtl/cassette_pkg.sv
// Shared definitions for the MC-10 cassette player and recorder.
package cassette_pkg;

  localparam int TAPE_CNT_W = 16;

  typedef enum logic [1:0] {
    REC_OFF   = 2'd0,
    REC_ARMED = 2'd1,
    REC_RUN   = 2'd2
  } rec_state_t;

  // Clock cycles per period of a tone at hz, truncated.
  function automatic int period_cyc(input int hz, input int clk_hz);
    return clk_hz / hz;
  endfunction

endpackage

// File: rtl/cassette_rec_edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sync[1:0] are the synchronizer stages, sync[2] holds the previous level.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], din};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder: times cout rising edges, decodes 2400/1200 Hz cycles into
// bits, packs them LSB-first and presents bytes on a one-entry valid/ready holder.
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int CLK_HZ      = 28_636_363,
  parameter int MIN_CYC     = period_cyc(4800, CLK_HZ),
  parameter int THRESH_CYC  = period_cyc(1800, CLK_HZ),
  parameter int TIMEOUT_CYC = period_cyc(600, CLK_HZ)
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  rec,
  input  logic                  cout,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TAPE_CNT_W-1:0] out_addr,
  output logic [TAPE_CNT_W-1:0] byte_count,
  output logic                  overflow,
  output logic [1:0]            state
);

  localparam logic [TAPE_CNT_W-1:0] MIN_L     = TAPE_CNT_W'(MIN_CYC);
  localparam logic [TAPE_CNT_W-1:0] THRESH_L  = TAPE_CNT_W'(THRESH_CYC);
  localparam logic [TAPE_CNT_W-1:0] TIMEOUT_L = TAPE_CNT_W'(TIMEOUT_CYC);
  localparam logic [TAPE_CNT_W-1:0] CNT_ONE   = TAPE_CNT_W'(1);
  localparam logic [TAPE_CNT_W-1:0] CNT_MAX   = '1;

  rec_state_t            cur_state;
  logic                  edge_pulse;
  logic                  rec_q;
  logic [TAPE_CNT_W-1:0] period_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  bit_take;
  logic                  bit_val;
  logic                  byte_done;
  logic [7:0]            next_byte;
  logic                  accept;
  logic                  rec_rise;

  edge_sync u_cout_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .din   (cout),
    .pulse (edge_pulse)
  );

  // An edge at the timeout count is a gap, not a bit; short periods are glitches.
  always_comb begin
    bit_take = 1'b0;
    bit_val  = 1'b0;
    if (rec && cur_state == REC_RUN && edge_pulse &&
        period_cnt < TIMEOUT_L && period_cnt >= MIN_L) begin
      bit_take = 1'b1;
      bit_val  = (period_cnt < THRESH_L);
    end
  end

  assign next_byte = {bit_val, shift_reg[7:1]};
  assign byte_done = bit_take && (bit_cnt == 3'd7);
  assign accept    = out_valid & out_ready;
  assign rec_rise  = rec & ~rec_q & (cur_state == REC_OFF);
  assign state     = cur_state;

  // The period counter restarts at 1 so at the next edge it equals the cycles elapsed.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= REC_OFF;
      rec_q      <= 1'b0;
      period_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      rec_q <= rec;
      if (!rec) begin
        cur_state <= REC_OFF;
        bit_cnt   <= '0;
      end else begin
        case (cur_state)
          REC_OFF: begin
            if (!rec_q) cur_state <= REC_ARMED;
          end
          REC_ARMED: begin
            if (edge_pulse) begin
              period_cnt <= CNT_ONE;
              cur_state  <= REC_RUN;
            end
          end
          REC_RUN: begin
            if (period_cnt >= TIMEOUT_L) begin
              cur_state <= REC_ARMED;
              bit_cnt   <= '0;
            end else if (bit_take) begin
              period_cnt <= CNT_ONE;
              bit_cnt    <= bit_cnt + 3'd1;
              shift_reg  <= next_byte;
            end else if (period_cnt != CNT_MAX) begin
              period_cnt <= period_cnt + CNT_ONE;
            end
          end
          default: cur_state <= REC_OFF;
        endcase
      end
    end
  end

  // One-entry output holder; a new byte may load in the same cycle the old one leaves.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (rec_rise) begin
        out_addr   <= '0;
        byte_count <= '0;
        overflow   <= 1'b0;
      end else if (accept) begin
        out_addr   <= out_addr + CNT_ONE;
        byte_count <= byte_count + CNT_ONE;
      end

      if (byte_done && (!out_valid || accept)) begin
        out_data  <= next_byte;
        out_valid <= 1'b1;
      end else if (byte_done) begin
        overflow <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
